// File: rtl/pattern_sequencer.sv
// Serial pattern generator: shifts a PATTERN_W-bit word out MSB first, one bit
// per DIV_COUNT-cycle period, with one-shot/continuous modes and a mid-bit strobe.
module pattern_sequencer #(
   parameter int DIV_COUNT = 50_000_000,
   parameter int PATTERN_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 mode,
   input  logic [PATTERN_W-1:0] pattern,
   output logic                 out,
   output logic                 hzClk,
   output logic                 busy,
   output logic                 done
);
   //  state | meaning
   //  IDLE  | waiting for start, out/busy low
   //  RUN   | shifting pattern out, busy high
   //  DONE  | one-cycle done pulse after a one-shot sequence

   if (DIV_COUNT < 2 || (DIV_COUNT % 2) != 0) begin : g_bad_div
      $error("pattern_sequencer: DIV_COUNT must be even and >= 2");
   end
   if (PATTERN_W < 1) begin : g_bad_width
      $error("pattern_sequencer: PATTERN_W must be >= 1");
   end

   localparam int CW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
   localparam int BW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV_COUNT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV_COUNT / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(PATTERN_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [PATTERN_W-1:0] shreg;
   logic [PATTERN_W-1:0] snap;
   logic [BW-1:0]        bitcnt;
   logic                 mode_q;
   logic                 tick;

   assign tick  = (cnt == CNT_MAX);
   assign hzClk = (cnt >= CNT_HALF);
   // shreg is cleared whenever RUN is left, so its MSB is the serial output directly
   assign out   = shreg[PATTERN_W-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         shreg  <= '0;
         snap   <= '0;
         bitcnt <= '0;
         mode_q <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         cnt  <= tick ? '0 : cnt + CW'(1);
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state  <= RUN;
                  shreg  <= pattern;
                  snap   <= pattern;
                  mode_q <= mode;
                  bitcnt <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
                  shreg <= '0;
                  busy  <= 1'b0;
               end else if (tick) begin
                  if (bitcnt != BIT_LAST) begin
                     shreg  <= shreg << 1;
                     bitcnt <= bitcnt + BW'(1);
                  end else if (mode_q) begin
                     shreg  <= snap;
                     bitcnt <= '0;
                  end else begin
                     state <= DONE;
                     shreg <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               shreg <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
